// File: rtl/nms_frame_scheduler_if.sv
// Pixel-issue / result-return bundle between the frame scheduler (master)
// and the NMS datapath (slave).
interface nms_frame_scheduler_if #(
  parameter int unsigned COORD_W = 16
);
  logic               px_valid;
  logic               px_ready;
  logic [COORD_W-1:0] px_row;
  logic [COORD_W-1:0] px_col;
  logic               px_border;
  logic               res_valid;

  modport master (
    output px_valid,
    output px_row,
    output px_col,
    output px_border,
    input  px_ready,
    input  res_valid
  );

  modport slave (
    input  px_valid,
    input  px_row,
    input  px_col,
    input  px_border,
    output px_ready,
    output res_valid
  );
endinterface

// File: rtl/nms_frame_scheduler.sv
// NMS frame scheduler: walks a WIDTH x HEIGHT frame in raster order, flags border
// pixels, throttles interior pixels to MAX_OUTSTANDING un-returned results and
// pulses done once every result is back.
// Optional build macro NMS_SCHED_PERF_EN adds a 32-bit perf_cycles counter port.
module nms_frame_scheduler #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned HEIGHT          = 5,
  parameter int unsigned COORD_W         = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  nms_frame_scheduler_if.master px_if,
  output logic                  busy,
  output logic                  done,
`ifdef NMS_SCHED_PERF_EN
  output logic [31:0]           perf_cycles,
`endif
  output logic                  err_overflow
);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  localparam int unsigned       CntW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [COORD_W-1:0] LastCol = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] LastRow = COORD_W'(HEIGHT - 1);
  localparam logic [CntW-1:0]    MaxCnt  = CntW'(MAX_OUTSTANDING);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic               border_q, border_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic xfer;
  logic inc;
  logic dec;

  function automatic logic is_border(input logic [COORD_W-1:0] r, input logic [COORD_W-1:0] c);
    return (r == '0) || (r == LastRow) || (c == '0) || (c == LastCol);
  endfunction

  assign xfer = valid_q & px_if.px_ready;
  assign inc  = xfer & ~border_q;
  assign dec  = px_if.res_valid;

  // Outstanding interior results and sticky overflow flag.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (dec && (cnt_q == '0)) begin
      err_d = 1'b1;
    end
    if (inc && !dec) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!inc && dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Frame FSM next state and registered-output next values.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    border_d = border_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StScan;
          row_d    = '0;
          col_d    = '0;
          border_d = 1'b1;
          valid_d  = 1'b1;
        end
      end
      StScan: begin
        if (xfer) begin
          if ((row_q == LastRow) && (col_q == LastCol)) begin
            state_d  = StDrain;
            row_d    = '0;
            col_d    = '0;
            border_d = 1'b0;
            valid_d  = 1'b0;
          end else begin
            if (col_q == LastCol) begin
              col_d = '0;
              row_d = row_q + COORD_W'(1);
            end else begin
              col_d = col_q + COORD_W'(1);
            end
            border_d = is_border(row_d, col_d);
            // Throttle uses the post-update count so a return re-opens issue next cycle.
            valid_d  = !(!border_d && (cnt_d == MaxCnt));
          end
        end else begin
          // Held coordinate; count can only fall here, so valid never drops once high.
          valid_d = !(!border_q && (cnt_d == MaxCnt));
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      border_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      border_q <= border_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef NMS_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Cycle counter: cleared on frame start, counts SCAN+DRAIN, saturates.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == StIdle) && enable) begin
      perf_d = '0;
    end else if (((state_q == StScan) || (state_q == StDrain)) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Perf counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign px_if.px_valid  = valid_q;
  assign px_if.px_row    = row_q;
  assign px_if.px_col    = col_q;
  assign px_if.px_border = border_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_overflow    = err_q;

endmodule
